// File: rtl/bus_arbiter_if.sv
// Bus arbiter handshake bundle: request/data/lock from the sources and the
// registered bus result back to them.
interface bus_arbiter_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SOURCES = 24
);
    localparam int unsigned SEL_W = $clog2(SOURCES);

    logic [SOURCES-1:0]       req;
    logic [SOURCES*WIDTH-1:0] data_in;
    logic                     lock;
    logic [WIDTH-1:0]         bus_out;
    logic [SOURCES-1:0]       grant;
    logic [SEL_W-1:0]         sel;
    logic                     valid;
    logic                     collision;

    modport master (
        output req, data_in, lock,
        input  bus_out, grant, sel, valid, collision
    );

    modport slave (
        input  req, data_in, lock,
        output bus_out, grant, sel, valid, collision
    );
endinterface

// File: rtl/bus_arbiter.sv
// Registered bus arbiter: fixed-priority or round-robin choice among SOURCES
// requesters, with lock-based ownership hold and collision flag.
module bus_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SOURCES = 24,
    parameter int unsigned MODE    = 0
) (
    input  logic           clk,
    input  logic           clr,
    bus_arbiter_if.slave   bus
);
    localparam int unsigned SEL_W = $clog2(SOURCES);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(SOURCES - 1);

    logic [SOURCES-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   bus_q, bus_d;
    logic               valid_q, valid_d;
    logic               collision_q, collision_d;

    logic               owner_req;
    logic               hold;
    logic               found_hi, found_lo;
    logic [SEL_W-1:0]   win_hi, win_lo, win, idx;
    logic [WIDTH-1:0]   word;

    // Winner search: win_lo is the lowest set bit, win_hi the lowest set bit above rr_ptr.
    always_comb begin
        owner_req = 1'b0;
        found_hi  = 1'b0;
        found_lo  = 1'b0;
        win_hi    = '0;
        win_lo    = '0;
        for (int i = 0; i < int'(SOURCES); i++) begin
            if (SEL_W'(i) == sel_q) owner_req = bus.req[i];
            if (bus.req[i] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = SEL_W'(i);
            end
            if (bus.req[i] && !found_hi && (SEL_W'(i) > rr_ptr_q)) begin
                found_hi = 1'b1;
                win_hi   = SEL_W'(i);
            end
        end
        hold = valid_q && bus.lock && owner_req;
        win  = (MODE == 1 && found_hi) ? win_hi : win_lo;
        idx  = hold ? sel_q : win;
    end

    // Word mux by index compare, so no out-of-range index can be formed.
    always_comb begin
        word = '0;
        for (int i = 0; i < int'(SOURCES); i++) begin
            if (SEL_W'(i) == idx) word = bus.data_in[i*WIDTH +: WIDTH];
        end
    end

    // Next-state: hold, idle, or arbitrate.
    always_comb begin
        grant_d     = '0;
        sel_d       = '0;
        bus_d       = '0;
        valid_d     = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        collision_d = |(bus.req & (bus.req - SOURCES'(1)));

        if (hold) begin
            grant_d = grant_q;
            sel_d   = sel_q;
            bus_d   = word;
            valid_d = 1'b1;
        end else if (bus.req != '0) begin
            for (int i = 0; i < int'(SOURCES); i++) begin
                grant_d[i] = (SEL_W'(i) == win);
            end
            sel_d   = win;
            bus_d   = word;
            valid_d = 1'b1;
            if (MODE == 1) rr_ptr_d = win;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            grant_q     <= '0;
            sel_q       <= '0;
            bus_q       <= '0;
            valid_q     <= 1'b0;
            collision_q <= 1'b0;
            rr_ptr_q    <= LAST_IDX;
        end else begin
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            bus_q       <= bus_d;
            valid_q     <= valid_d;
            collision_q <= collision_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.bus_out   = bus_q;
    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.valid     = valid_q;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one fixed-priority and one round-robin
// instance driven with identical stimulus.
module tb_bus_arbiter;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SOURCES = 24;

    logic                     clk;
    logic                     clr;
    logic [SOURCES-1:0]       req;
    logic [SOURCES*WIDTH-1:0] data_in;
    logic                     lock;

    int checks;
    int errors;

    bus_arbiter_if #(.WIDTH(WIDTH), .SOURCES(SOURCES)) if0 ();
    bus_arbiter_if #(.WIDTH(WIDTH), .SOURCES(SOURCES)) if1 ();

    assign if0.req     = req;
    assign if0.data_in = data_in;
    assign if0.lock    = lock;
    assign if1.req     = req;
    assign if1.data_in = data_in;
    assign if1.lock    = lock;

    bus_arbiter #(.WIDTH(WIDTH), .SOURCES(SOURCES), .MODE(0)) dut0 (
        .clk (clk),
        .clr (clr),
        .bus (if0.slave)
    );

    bus_arbiter #(.WIDTH(WIDTH), .SOURCES(SOURCES), .MODE(1)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (if1.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        clr = 1'b0;
        #1;
        clr = 1'b1;
    endtask

    task automatic set_word(input int i, input logic [WIDTH-1:0] w);
        data_in[i*WIDTH +: WIDTH] = w;
    endtask

    task automatic test_reset();
        req  = '1;
        lock = 1'b0;
        step();
        step();
        #2;
        clr = 1'b0;
        #1;
        checks++;
        if (if1.bus_out !== 32'h0) begin errors++; $display("FAIL reset_bus got %h exp %h", if1.bus_out, 32'h0); end
        checks++;
        if (if1.grant !== 24'h0) begin errors++; $display("FAIL reset_grant got %h exp %h", if1.grant, 24'h0); end
        checks++;
        if (if1.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if1.valid); end
        checks++;
        if (if1.collision !== 1'b0) begin errors++; $display("FAIL reset_collision got %b exp 0", if1.collision); end
        clr = 1'b1;
        step();
        checks++;
        if (if1.sel !== 5'd0 || if1.grant !== 24'h000001) begin
            errors++; $display("FAIL reset_first_rr got sel %0d grant %h exp sel 0 grant 000001", if1.sel, if1.grant);
        end
        checks++;
        if (if1.bus_out !== 32'hA000_0000) begin errors++; $display("FAIL reset_first_bus got %h exp %h", if1.bus_out, 32'hA000_0000); end
    endtask

    task automatic test_fixed();
        pulse_reset();
        lock = 1'b0;
        req  = 24'h000A00;
        set_word(9, 32'hDEADBEEF);
        step();
        checks++;
        if (if0.sel !== 5'd9) begin errors++; $display("FAIL fixed_sel got %0d exp 9", if0.sel); end
        checks++;
        if (if0.grant !== 24'h000200) begin errors++; $display("FAIL fixed_grant got %h exp 000200", if0.grant); end
        checks++;
        if (if0.bus_out !== 32'hDEADBEEF) begin errors++; $display("FAIL fixed_bus got %h exp deadbeef", if0.bus_out); end
        checks++;
        if (if0.valid !== 1'b1 || if0.collision !== 1'b1) begin
            errors++; $display("FAIL fixed_status got valid %b coll %b exp 1 1", if0.valid, if0.collision);
        end
        req = 24'h800000;
        step();
        checks++;
        if (if0.sel !== 5'd23 || if0.collision !== 1'b0) begin
            errors++; $display("FAIL fixed_top got sel %0d coll %b exp 23 0", if0.sel, if0.collision);
        end
        set_word(9, 32'hA000_0009);
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_sel [4];
        exp_sel[0] = 5'd0;
        exp_sel[1] = 5'd1;
        exp_sel[2] = 5'd23;
        exp_sel[3] = 5'd0;
        pulse_reset();
        lock = 1'b0;
        req  = 24'h800003;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (if1.sel !== exp_sel[k] || if1.collision !== 1'b1) begin
                errors++; $display("FAIL rr_step%0d got sel %0d coll %b exp sel %0d coll 1", k, if1.sel, if1.collision, exp_sel[k]);
            end
        end
        checks++;
        if (if0.sel !== 5'd0) begin errors++; $display("FAIL rr_fixed_ref got %0d exp 0", if0.sel); end
    endtask

    task automatic test_lock();
        pulse_reset();
        lock = 1'b0;
        req  = 24'h800000;
        step();
        checks++;
        if (if1.sel !== 5'd23) begin errors++; $display("FAIL lock_acquire got %0d exp 23", if1.sel); end
        lock = 1'b1;
        req  = 24'h800001;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (if1.sel !== 5'd23 || if1.grant !== 24'h800000) begin
                errors++; $display("FAIL lock_hold%0d got sel %0d grant %h exp 23 800000", k, if1.sel, if1.grant);
            end
        end
        checks++;
        if (if0.sel !== 5'd23) begin errors++; $display("FAIL lock_hold_fixed got %0d exp 23", if0.sel); end
        set_word(23, 32'h1);
        step();
        checks++;
        if (if1.bus_out !== 32'h1) begin errors++; $display("FAIL lock_data1 got %h exp 1", if1.bus_out); end
        set_word(23, 32'h2);
        #1;
        checks++;
        if (if1.bus_out !== 32'h1) begin errors++; $display("FAIL lock_data_early got %h exp 1", if1.bus_out); end
        step();
        checks++;
        if (if1.bus_out !== 32'h2) begin errors++; $display("FAIL lock_data2 got %h exp 2", if1.bus_out); end
        req = 24'h000001;
        step();
        checks++;
        if (if1.sel !== 5'd0 || if1.bus_out !== 32'hA000_0000) begin
            errors++; $display("FAIL lock_release got sel %0d bus %h exp 0 a0000000", if1.sel, if1.bus_out);
        end
        lock = 1'b0;
        set_word(23, 32'hA000_0017);
    endtask

    task automatic test_idle();
        pulse_reset();
        lock = 1'b0;
        req  = 24'h000008;
        step();
        checks++;
        if (if1.sel !== 5'd3) begin errors++; $display("FAIL idle_pre got %0d exp 3", if1.sel); end
        req = '0;
        step();
        step();
        checks++;
        if (if1.valid !== 1'b0 || if1.grant !== 24'h0 || if1.sel !== 5'd0 || if1.bus_out !== 32'h0) begin
            errors++; $display("FAIL idle_outputs got v %b g %h s %0d b %h exp 0 0 0 0", if1.valid, if1.grant, if1.sel, if1.bus_out);
        end
        req = 24'h000011;
        step();
        checks++;
        if (if1.sel !== 5'd4 || if1.bus_out !== 32'hA000_0004) begin
            errors++; $display("FAIL idle_rr_kept got sel %0d bus %h exp 4 a0000004", if1.sel, if1.bus_out);
        end
        checks++;
        if (if0.sel !== 5'd0) begin errors++; $display("FAIL idle_fixed got %0d exp 0", if0.sel); end
    endtask

    task automatic test_single_lock();
        pulse_reset();
        lock = 1'b1;
        req  = 24'h000001;
        set_word(0, 32'h0000_0055);
        step();
        checks++;
        if (if1.sel !== 5'd0 || if1.collision !== 1'b0 || if1.bus_out !== 32'h55) begin
            errors++; $display("FAIL single_first got sel %0d coll %b bus %h exp 0 0 55", if1.sel, if1.collision, if1.bus_out);
        end
        set_word(0, 32'h0000_0066);
        #1;
        checks++;
        if (if1.bus_out !== 32'h55) begin errors++; $display("FAIL single_early got %h exp 55", if1.bus_out); end
        step();
        checks++;
        if (if1.bus_out !== 32'h66 || if1.valid !== 1'b1) begin
            errors++; $display("FAIL single_track got bus %h v %b exp 66 1", if1.bus_out, if1.valid);
        end
        lock = 1'b0;
        set_word(0, 32'hA000_0000);
    endtask

    task automatic test_hold_priority();
        pulse_reset();
        lock = 1'b1;
        req  = 24'h000020;
        step();
        checks++;
        if (if0.sel !== 5'd5) begin errors++; $display("FAIL prio_idle_lock got %0d exp 5", if0.sel); end
        req = 24'h000022;
        step();
        checks++;
        if (if0.sel !== 5'd5 || if0.collision !== 1'b1) begin
            errors++; $display("FAIL prio_hold got sel %0d coll %b exp 5 1", if0.sel, if0.collision);
        end
        lock = 1'b0;
        step();
        checks++;
        if (if0.sel !== 5'd1 || if0.grant !== 24'h000002) begin
            errors++; $display("FAIL prio_unlock got sel %0d grant %h exp 1 000002", if0.sel, if0.grant);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        clr    = 1'b0;
        req    = '0;
        lock   = 1'b0;
        for (int i = 0; i < int'(SOURCES); i++) data_in[i*WIDTH +: WIDTH] = 32'hA000_0000 | 32'(i);
        #12;
        clr = 1'b1;
        test_reset();
        test_fixed();
        test_round_robin();
        test_lock();
        test_idle();
        test_single_lock();
        test_hold_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
